// File: rtl/div_rest_4b.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// Optional macro DIV_ZERO_CHECK_EN short-circuits B=0 to an immediate result with div0 set.
module div_rest_4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);

  // Handshake: start is a request sampled only in IDLE; done is a one-cycle
  // strobe marking Q/R/div0 valid, and those outputs hold until the next result.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   trial;
`ifdef DIV_ZERO_CHECK_EN
  logic             div0_q, div0_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
`ifdef DIV_ZERO_CHECK_EN
    div0_d  = div0_q;
`endif
    p_shift = {p_q[WIDTH-1:0], a_q[cnt_q]};
    trial   = p_shift - {1'b0, b_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          p_d     = '0;
          quo_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_CALC;
`ifdef DIV_ZERO_CHECK_EN
          if (B == '0) begin
            q_d     = '1;
            r_d     = A;
            div0_d  = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        // A set top bit of the trial difference is a borrow: keep the shifted value.
        if (!trial[WIDTH]) begin
          p_d          = trial;
          quo_d[cnt_q] = 1'b1;
        end else begin
          p_d          = p_shift;
          quo_d[cnt_q] = 1'b0;
        end
        if (cnt_q == '0) begin
          q_d     = quo_d;
          r_d     = p_d[WIDTH-1:0];
`ifdef DIV_ZERO_CHECK_EN
          div0_d  = 1'b0;
`endif
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      div0_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIV_ZERO_CHECK_EN
      div0_q  <= div0_d;
`endif
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef DIV_ZERO_CHECK_EN
  assign div0 = div0_q;
`else
  assign div0 = 1'b0;
`endif

endmodule

// File: tb/tb_div_rest_4b.sv
// Self-checking bench for div_rest_4b against an arithmetic reference (/ and %).
module tb_div_rest_4b;

  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in  = '0;
  logic [W-1:0] b_in  = '0;
  logic [W-1:0] q_out;
  logic [W-1:0] r_out;
  logic         busy;
  logic         done;
  logic         div0;

  int checks = 0;
  int errors = 0;

  div_rest_4b #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .Q     (q_out),
    .R     (r_out),
    .busy  (busy),
    .done  (done),
    .div0  (div0)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return '1;
    return a / b;
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return a;
    return a % b;
  endfunction

  function automatic logic ref_div0(input logic [W-1:0] b);
`ifdef DIV_ZERO_CHECK_EN
    return (b == '0);
`else
    return (b == '0) && 1'b0;
`endif
  endfunction

  function automatic int ref_lat(input logic [W-1:0] b);
`ifdef DIV_ZERO_CHECK_EN
    if (b == '0) return 0;
`endif
    return (b == '0) ? W : W;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (q_out !== '0)  begin errors++; $display("FAIL reset_q got %0d want 0", q_out); end
    checks++; if (r_out !== '0)  begin errors++; $display("FAIL reset_r got %0d want 0", r_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL reset_div0 got %b want 0", div0); end
    rst_n = 1'b1;
    tick();
  endtask

  // 13/3 with a cycle-by-cycle look at busy/done and held outputs during the run.
  task automatic test_timing_13_3();
    launch(4'd13, 4'd3);
    for (int i = 0; i <= W + 1; i++) begin
      checks++;
      if (busy !== (i <= W)) begin
        errors++; $display("FAIL t13_busy idx %0d got %b want %b", i, busy, (i <= W));
      end
      checks++;
      if (done !== (i == W)) begin
        errors++; $display("FAIL t13_done idx %0d got %b want %b", i, done, (i == W));
      end
      if (i < W) begin
        checks++;
        if (q_out !== '0 || r_out !== '0) begin
          errors++; $display("FAIL t13_hold idx %0d got q=%0d r=%0d want q=0 r=0", i, q_out, r_out);
        end
      end
      if (i == W) begin
        checks++;
        if (q_out !== 4'd4 || r_out !== 4'd1 || div0 !== 1'b0) begin
          errors++; $display("FAIL t13_result got q=%0d r=%0d d0=%b want q=4 r=1 d0=0", q_out, r_out, div0);
        end
      end
      tick();
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[5];
    logic [W-1:0] tb[5];
    int lat;
    ta = '{4'd15, 4'd5, 4'd0, 4'd9, 4'd0};
    tb = '{4'd1,  4'd7, 4'd9, 4'd0, 4'd0};
    for (int k = 0; k < 5; k++) begin
      launch(ta[k], tb[k]);
      wait_done(lat);
      checks++;
      if (lat !== ref_lat(tb[k])) begin
        errors++; $display("FAIL dir_latency %0d/%0d got %0d want %0d", ta[k], tb[k], lat, ref_lat(tb[k]));
      end
      checks++;
      if (q_out !== ref_q(ta[k], tb[k]) || r_out !== ref_r(ta[k], tb[k]) || div0 !== ref_div0(tb[k])) begin
        errors++;
        $display("FAIL dir_result %0d/%0d got q=%0d r=%0d d0=%b want q=%0d r=%0d d0=%b",
                 ta[k], tb[k], q_out, r_out, div0, ref_q(ta[k], tb[k]), ref_r(ta[k], tb[k]), ref_div0(tb[k]));
      end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL dir_idle got busy=%b done=%b want 0 0", busy, done);
      end
    end
  endtask

  task automatic test_start_ignored();
    int done_cnt = 0;
    launch(4'd13, 4'd3);
    for (int i = 0; i <= W + 4; i++) begin
      if (i == 1) begin start = 1'b1; a_in = 4'd2; b_in = 4'd1; end
      if (i == 3) begin start = 1'b0; a_in = 4'd7; b_in = 4'd5; end
      if (done === 1'b1) begin
        done_cnt++;
        checks++;
        if (i != W || q_out !== 4'd4 || r_out !== 4'd1) begin
          errors++; $display("FAIL ign_result idx %0d got q=%0d r=%0d want idx %0d q=4 r=1", i, q_out, r_out, W);
        end
      end
      tick();
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL ign_done_count got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    int lat;
    launch(4'd13, 4'd3);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (q_out !== '0 || r_out !== '0 || busy !== 1'b0 || done !== 1'b0 || div0 !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs got q=%0d r=%0d busy=%b done=%b d0=%b want all 0", q_out, r_out, busy, done, div0);
    end
    for (int i = 0; i < W + 3; i++) begin
      if (done === 1'b1) done_cnt++;
      tick();
    end
    checks++;
    if (done_cnt != 0) begin
      errors++; $display("FAIL rstmid_no_done got %0d pulses want 0", done_cnt);
    end
    launch(4'd6, 4'd4);
    wait_done(lat);
    checks++;
    if (lat != W || q_out !== 4'd1 || r_out !== 4'd2) begin
      errors++; $display("FAIL rstmid_fresh got lat=%0d q=%0d r=%0d want lat=%0d q=1 r=2", lat, q_out, r_out, W);
    end
    tick();
  endtask

  // Exhaustive nonzero-divisor sweep, then random pairs including B=0.
  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int n = 0; n < 256 + 60; n++) begin
      if (n < 256) begin
        a = W'(n / 16);
        b = W'(n % 16);
      end else begin
        a = W'($urandom_range(0, 15));
        b = W'($urandom_range(0, 15));
      end
      if (n < 256 && b == '0) continue;
      launch(a, b);
      wait_done(lat);
      checks++;
      if (lat != ref_lat(b) || q_out !== ref_q(a, b) || r_out !== ref_r(a, b) || div0 !== ref_div0(b)) begin
        errors++;
        $display("FAIL b2b %0d/%0d got lat=%0d q=%0d r=%0d d0=%b want lat=%0d q=%0d r=%0d d0=%b",
                 a, b, lat, q_out, r_out, div0, ref_lat(b), ref_q(a, b), ref_r(a, b), ref_div0(b));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_timing_13_3();
    test_directed();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
